serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 181 ++++++++++++++++++
 tb/tb_serial_adder.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//
// Multi-cycle unsigned adder/subtractor. Operands are captured on a start
// handshake in IDLE and processed LSB-first, DIGIT bits per clock, through a
// single DIGIT-wide ripple slice whose carry is held in a register between
// clocks. The WIDTH+1-bit result is published together with a one-cycle done
// pulse, and then held until the next completion or reset.
//
// Parameters:
//   WIDTH  operand width in bits (>= 1)
//   DIGIT  bits processed per clock; must divide WIDTH exactly
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request, sampled only in IDLE
//   sub    in   0: a+b, 1: a-b (sampled with start)
//   a, b   in   unsigned operands, WIDTH bits (sampled with start)
//   busy   out  high while slices are being processed
//   done   out  one-cycle pulse when r takes a new value
//   ovf    out  signed overflow of the last result (SERIAL_ADDER_OVF_EN only)
//   r      out  result, WIDTH+1 bits; r[WIDTH] is the carry out
//
// Build option:
//   SERIAL_ADDER_OVF_EN  adds the ovf output and its register.
//
// State table:
//   IDLE | waiting for start; r and ovf hold the last result
//   RUN  | one slice per clock; the last slice loads r and raises done
//   DONE | done high for this cycle only; returns to IDLE on the next edge
// ---------------------------------------------------------------------------
module serial_adder #(
  parameter int WIDTH = 4,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic [WIDTH:0]   r
);

  // Guarded so a bad DIGIT reports the $error below instead of dividing by 0.
  localparam int N = (DIGIT > 0) ? WIDTH / DIGIT : 1;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  generate
    if (WIDTH < 1) begin : g_bad_width
      $error("serial_adder: WIDTH must be >= 1");
    end
    if ((DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_digit
      $error("serial_adder: DIGIT must be >= 1 and divide WIDTH exactly");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH:0]   r_q;

  // One DIGIT-wide ripple slice over the low bits of the shifting operands.
  logic [DIGIT:0]   slice;
  logic [DIGIT-1:0] slice_sum;
  logic             slice_cout;
  logic [WIDTH-1:0] sum_d;

  assign slice      = {1'b0, opa_q[DIGIT-1:0]}
                    + {1'b0, opb_q[DIGIT-1:0]}
                    + {{DIGIT{1'b0}}, carry_q};
  assign slice_sum  = slice[DIGIT-1:0];
  assign slice_cout = slice[DIGIT];

  // Sum bits enter from the MSB side so that after N slices the first slice
  // has reached bit 0. With a single slice there is nothing to shift.
  generate
    if (DIGIT == WIDTH) begin : g_sum_single
      assign sum_d = slice_sum;
    end else begin : g_sum_shift
      assign sum_d = {slice_sum, sum_q[WIDTH-1:DIGIT]};
    end
  endgenerate

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_q;
  logic msb_cin;

  // Carry into the slice MSB recovered from its sum bit: s = a ^ b ^ cin.
  assign msb_cin = slice_sum[DIGIT-1] ^ opa_q[DIGIT-1] ^ opb_q[DIGIT-1];
  assign ovf     = ovf_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      r_q     <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            // Subtraction as a + ~b + 1: the +1 rides in on the initial carry.
            opa_q   <= a;
            opb_q   <= sub ? ~b : b;
            carry_q <= sub;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end

        RUN: begin
          opa_q   <= opa_q >> DIGIT;
          opb_q   <= opb_q >> DIGIT;
          carry_q <= slice_cout;
          sum_q   <= sum_d;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            r_q     <= {slice_cout, sum_d};
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= msb_cin ^ slice_cout;
`endif
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end

        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign r    = r_q;

  a_done_single : assert property (@(posedge clk) disable iff (!rst_n)
                                   done_q |=> !done_q);
  a_busy_done_excl : assert property (@(posedge clk) disable iff (!rst_n)
                                      !(busy_q && done_q));

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // WIDTH=4, DIGIT=1
  logic       start4, sub4;
  logic [3:0] a4, b4;
  logic       busy4, done4;
  logic [4:0] r4;

  // WIDTH=8 with DIGIT=2 and DIGIT=8, driven in lockstep
  logic       start8, sub8;
  logic [7:0] a8, b8;
  logic       busy82, done82, busy88, done88;
  logic [8:0] r82, r88;

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf4, ovf82, ovf88;
`endif

  int checks = 0;
  int errors = 0;

  serial_adder #(.WIDTH(4), .DIGIT(1)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4), .a(a4), .b(b4),
    .busy(busy4), .done(done4),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf(ovf4),
`endif
    .r(r4)
  );

  serial_adder #(.WIDTH(8), .DIGIT(2)) dut82 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy82), .done(done82),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf(ovf82),
`endif
    .r(r82)
  );

  serial_adder #(.WIDTH(8), .DIGIT(8)) dut88 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy88), .done(done88),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf(ovf88),
`endif
    .r(r88)
  );

  task automatic test_reset();
    rst_n = 1'b0;
    start4 = 1'b0; sub4 = 1'b0; a4 = 4'h0; b4 = 4'h0;
    start8 = 1'b0; sub8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    #2;
    checks++;
    if ({busy4, done4, r4} !== 7'b0) begin
      errors++; $display("FAIL reset_dut4: got %b expected 0000000", {busy4, done4, r4});
    end
    checks++;
    if ({busy82, done82, r82} !== 11'b0) begin
      errors++; $display("FAIL reset_dut82: got %b expected 0", {busy82, done82, r82});
    end
    checks++;
    if ({busy88, done88, r88} !== 11'b0) begin
      errors++; $display("FAIL reset_dut88: got %b expected 0", {busy88, done88, r88});
    end
`ifdef SERIAL_ADDER_OVF_EN
    checks++;
    if (ovf4 !== 1'b0) begin
      errors++; $display("FAIL reset_ovf: got %b expected 0", ovf4);
    end
`endif
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({busy4, done4} !== 2'b00) begin
      errors++; $display("FAIL idle_after_reset: got %b expected 00", {busy4, done4});
    end
  endtask

  task automatic test_basic();
    logic [3:0] ta [6] = '{4'b0111, 4'b1111, 4'b0101, 4'b0011, 4'b0000, 4'b0000};
    logic [3:0] tb [6] = '{4'b0011, 4'b1111, 4'b0011, 4'b0101, 4'b0000, 4'b0000};
    logic       ts [6] = '{1'b0,    1'b0,    1'b1,    1'b1,    1'b1,    1'b0};
    logic [4:0] te [6] = '{5'b01010, 5'b11110, 5'b10010, 5'b01110, 5'b10000, 5'b00000};
    logic [4:0] r_prev;
    int cyc;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      a4 = ta[i]; b4 = tb[i]; sub4 = ts[i]; start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
      // operands must already be latched
      a4 = ~a4; b4 = ~b4; sub4 = ~sub4;
      checks++;
      if (busy4 !== 1'b1) begin
        errors++; $display("FAIL basic_busy_start[%0d]: got %b expected 1", i, busy4);
      end
      r_prev = r4;
      cyc = 0;
      while (done4 !== 1'b1 && cyc < 20) begin
        @(posedge clk); #1;
        cyc++;
        if (done4 !== 1'b1) begin
          checks++;
          if (r4 !== r_prev || busy4 !== 1'b1) begin
            errors++;
            $display("FAIL basic_run_hold[%0d]: got r=%b busy=%b expected r=%b busy=1", i, r4, busy4, r_prev);
          end
        end
      end
      checks++;
      if (cyc !== 4) begin
        errors++; $display("FAIL basic_latency[%0d]: got %0d expected 4", i, cyc);
      end
      checks++;
      if (r4 !== te[i] || busy4 !== 1'b0) begin
        errors++; $display("FAIL basic_result[%0d]: got r=%b busy=%b expected r=%b busy=0", i, r4, busy4, te[i]);
      end
      @(posedge clk); #1;
      checks++;
      if (done4 !== 1'b0 || r4 !== te[i]) begin
        errors++; $display("FAIL basic_after_done[%0d]: got done=%b r=%b expected done=0 r=%b", i, done4, r4, te[i]);
      end
    end
  endtask

  task automatic test_ignored_start();
    logic [4:0] r_prev;
    int dn, fd;
    @(posedge clk); #1;
    a4 = 4'b0001; b4 = 4'b0010; sub4 = 1'b0; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    r_prev = r4;
    dn = 0; fd = -1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (k == 2) begin
        start4 = 1'b1; a4 = 4'b1111; b4 = 4'b1111;
      end else begin
        start4 = 1'b0;
      end
      if (done4 === 1'b1) begin
        dn++;
        if (fd < 0) fd = k;
      end
      if (fd < 0) begin
        checks++;
        if (r4 !== r_prev) begin
          errors++; $display("FAIL ignore_hold[%0d]: got %b expected %b", k, r4, r_prev);
        end
      end
    end
    checks++;
    if (dn !== 1 || fd !== 4) begin
      errors++; $display("FAIL ignore_done: got count=%0d at=%0d expected count=1 at=4", dn, fd);
    end
    checks++;
    if (r4 !== 5'b00011) begin
      errors++; $display("FAIL ignore_result: got %b expected 00011", r4);
    end
  endtask

  task automatic test_reset_abort();
    int dn, cyc;
    @(posedge clk); #1;
    a4 = 4'b0111; b4 = 4'b0011; sub4 = 1'b0; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy4, done4, r4} !== 7'b0) begin
      errors++; $display("FAIL abort_immediate: got %b expected 0000000", {busy4, done4, r4});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    dn = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (done4 === 1'b1 || busy4 === 1'b1) dn++;
    end
    checks++;
    if (dn !== 0 || r4 !== 5'b0) begin
      errors++; $display("FAIL abort_quiet: got activity=%0d r=%b expected 0 r=00000", dn, r4);
    end
    @(posedge clk); #1;
    a4 = 4'b0011; b4 = 4'b0101; sub4 = 1'b0; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    cyc = 0;
    while (done4 !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc !== 4 || r4 !== 5'b01000) begin
      errors++; $display("FAIL abort_restart: got cyc=%0d r=%b expected cyc=4 r=01000", cyc, r4);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int d1, d2;
    d1 = -1; d2 = -1;
    @(posedge clk); #1;
    a4 = 4'b0110; b4 = 4'b0101; sub4 = 1'b0; start4 = 1'b1;
    for (int k = 0; k < 18; k++) begin
      @(posedge clk); #1;
      if (done4 === 1'b1) begin
        if (d1 < 0) d1 = k;
        else if (d2 < 0) d2 = k;
      end
    end
    start4 = 1'b0;
    checks++;
    if (d1 !== 4 || d2 !== 10) begin
      errors++; $display("FAIL b2b_spacing: got %0d,%0d expected 4,10", d1, d2);
    end
    checks++;
    if (r4 !== 5'b01011) begin
      errors++; $display("FAIL b2b_result: got %b expected 01011", r4);
    end
    @(posedge clk); @(posedge clk); #1;
  endtask

  task automatic test_wide();
    logic [8:0] exp_r, got2, got8;
    int c2, c8, cyc;
    for (int i = 0; i <= 200; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        a8 = 8'hFF; b8 = 8'h01; sub8 = 1'b0;
      end else begin
        a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom_range(0, 1));
      end
      exp_r = sub8 ? ({1'b0, a8} + {1'b0, ~b8} + 9'd1) : ({1'b0, a8} + {1'b0, b8});
      start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      a8 = ~a8;
      c2 = -1; c8 = -1; cyc = 0;
      got2 = 'x; got8 = 'x;
      while ((c2 < 0 || c8 < 0) && cyc < 20) begin
        @(posedge clk); #1;
        cyc++;
        if (done82 === 1'b1 && c2 < 0) begin c2 = cyc; got2 = r82; end
        if (done88 === 1'b1 && c8 < 0) begin c8 = cyc; got8 = r88; end
      end
      checks++;
      if (c2 !== 4 || c8 !== 1) begin
        errors++; $display("FAIL wide_latency[%0d]: got %0d,%0d expected 4,1", i, c2, c8);
      end
      checks++;
      if (got2 !== exp_r) begin
        errors++; $display("FAIL wide_d2[%0d]: got %h expected %h", i, got2, exp_r);
      end
      checks++;
      if (got8 !== exp_r) begin
        errors++; $display("FAIL wide_d8[%0d]: got %h expected %h", i, got8, exp_r);
      end
      @(posedge clk); #1;
    end
  endtask

`ifdef SERIAL_ADDER_OVF_EN
  task automatic test_ovf();
    logic [3:0] ta [3] = '{4'b0111, 4'b1000, 4'b0011};
    logic [3:0] tb [3] = '{4'b0001, 4'b0001, 4'b0010};
    logic       ts [3] = '{1'b0,    1'b1,    1'b0};
    logic [4:0] te [3] = '{5'b01000, 5'b10111, 5'b00101};
    logic       to [3] = '{1'b1,    1'b1,    1'b0};
    int cyc;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      a4 = ta[i]; b4 = tb[i]; sub4 = ts[i]; start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
      cyc = 0;
      while (done4 !== 1'b1 && cyc < 20) begin
        @(posedge clk); #1;
        cyc++;
      end
      checks++;
      if (r4 !== te[i] || ovf4 !== to[i]) begin
        errors++; $display("FAIL ovf[%0d]: got r=%b ovf=%b expected r=%b ovf=%b", i, r4, ovf4, te[i], to[i]);
      end
      @(posedge clk); #1;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_ignored_start();
    test_reset_abort();
    test_back_to_back();
    test_wide();
`ifdef SERIAL_ADDER_OVF_EN
    test_ovf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
